rx_frame_deframer: RTL and testbench
====================================

Name: rx_frame_deframer

Overview:
- Sits directly downstream of the PCD->PICC sequence decoder. It consumes the decoded SOC, data-bit and EOC pulses and strips/checks the odd parity bit after every full byte.
- Assembles bytes LSb first and emits each byte with a valid-bit count; a short trailing byte (e.g. 7-bit REQA) carries its bit count.
- Keeps a running CRC_A over full bytes and reports the frame status at EOC to the protocol layer.

Parameters:
- None. Byte width is fixed at 8 bits; CRC_A is fixed at 16 bits with preset 16'h6363.

Ports:
- clk         in   1  system clock
- rst_n       in   1  asynchronous active-low reset
- in_soc      in   1  1-cycle pulse: start of comms detected
- in_eoc      in   1  1-cycle pulse: end of comms detected
- in_error    in   1  1-cycle pulse: illegal sequence detected by the upstream decoder
- in_bit      in   1  decoded data bit, qualified by in_bit_valid
- in_bit_valid in  1  1-cycle pulse: in_bit is valid
- out_soc     out  1  registered copy of in_soc
- out_data    out  8  assembled byte, LSb = first bit received
- out_bits    out  3  valid bits in out_data; 0 means 8
- out_valid   out  1  1-cycle pulse: out_data/out_bits valid
- out_eoc     out  1  1-cycle pulse: frame ended cleanly
- out_error   out  1  1-cycle pulse: parity or upstream error
- crc_ok      out  1  valid with out_eoc: CRC residue == 16'h0000 and no partial byte

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE, bit_cnt = 0.
  - CRC register = 16'h6363.
- Input pulses in_soc, in_eoc, in_error and in_bit_valid are mutually exclusive. The bench asserts this; the RTL gives in_soc the highest priority, then in_error, then in_eoc, then in_bit_valid.
- FSM states:
  - IDLE:
    - in_soc -> DATA; clear bit_cnt, shift register and CRC (to 6363).
    - All other inputs are ignored.
  - DATA:
    - in_bit_valid shifts in_bit into shift[bit_cnt] and increments bit_cnt.
    - When bit_cnt reaches 8 -> PARITY.
    - in_eoc with bit_cnt == 0 -> out_eoc = 1, crc_ok = (crc == 0), -> IDLE.
    - in_eoc with bit_cnt of 1..7 -> out_valid = 1, out_bits = bit_cnt, out_eoc = 1, crc_ok = 0, -> IDLE. The partial byte carries no parity and is not CRC-accumulated.
  - PARITY:
    - in_bit_valid with (^shift ^ in_bit) == 1 (odd parity OK) -> out_valid = 1, out_data = shift, out_bits = 0, CRC updated with shift, bit_cnt = 0, -> DATA.
    - in_bit_valid with a parity mismatch -> out_error = 1 and no out_valid, -> ERROR.
    - in_eoc (missing parity) -> out_error = 1, -> IDLE.
  - ERROR: ignore everything until in_soc, which restarts as from IDLE.
- in_error in DATA or PARITY -> out_error = 1, -> ERROR.
- in_soc in any state (mid-frame) -> discard the partial byte, restart DATA, pulse out_soc, with no error pulse.
- Latency: every output pulse is registered exactly 1 clk after the causing input pulse.
- out_data and out_bits hold their value until the next out_valid.
- CRC update follows the ISO/IEC 14443-3 CRC_A byte step; the residue over data plus appended LE CRC is 16'h0000.
- Asynchronous reset mid-frame returns to IDLE immediately with no output pulses.

Decomposition:
- The ISO14443A_pkg package gains:
  - CRC_A_PRESET = 16'h6363
  - CRC_A_RESIDUE = 16'h0000
  - an enum for the deframer FSM state
- Sub-module crc_a: single-cycle byte-wide CRC_A update with ports clk, rst_n, init, en, data[7:0], crc[15:0].

Test Plan:
- REQA: SOC, 7 bits of 8'h26 (LSb first, no parity), EOC -> one out_valid with out_data[6:0] = 7'h26 and out_bits = 7; out_eoc = 1 with crc_ok = 0; out_error never pulses.
- HLTA: SOC, bytes 50 00 57 CD, each followed by correct parity 1,1,0,0, then EOC -> four out_valid pulses with out_bits = 0 and data 50, 00, 57, CD; out_eoc with crc_ok = 1.
- Same HLTA stimulus with the last byte CC (and its correct parity 1) -> four bytes out, out_eoc with crc_ok = 0.
- Parity error: SOC, 8'h50 followed by parity 0 -> out_error pulse, no out_valid; subsequent bits and EOC are ignored; a new SOC with a valid frame is then decoded normally.
- Mid-frame SOC and in_error:
  - SOC, 5 bits, SOC, full 8'h93 with parity 1, EOC -> single out_valid with 93.
  - Separately: SOC, 3 bits, in_error -> out_error, then no out_eoc.
- Reset: assert rst_n low after 4 bits of a frame -> all outputs 0; after release, EOC alone produces nothing, and a fresh REQA frame decodes as in the first scenario.

Source files
------------

// File: rtl/rx_frame_deframer_pkg.sv
// Shared constants, FSM state type and the CRC_A byte step used by the
// PCD->PICC frame deframer.
package rx_frame_deframer_pkg;

  localparam int          BYTE_W        = 8;
  localparam logic [15:0] CRC_A_PRESET  = 16'h6363;
  localparam logic [15:0] CRC_A_RESIDUE = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_ERROR  = 2'd3
  } deframer_state_e;

  // One CRC_A byte step (reflected 0x1021), written in the byte-wise form
  // used by ISO/IEC 14443-3 so it can be compared against the reference code.
  function automatic logic [15:0] crc_a_step(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [7:0] ch;
    ch = data ^ crc[7:0];
    ch = ch ^ {ch[3:0], 4'b0000};
    crc_a_step = {8'h00, crc[15:8]}
               ^ {ch, 8'h00}
               ^ {5'b00000, ch, 3'b000}
               ^ {12'h000, ch[7:4]};
  endfunction

endpackage

// File: rtl/rx_frame_deframer_crc_a.sv
// Single-cycle byte-wide CRC_A register: init reloads the preset, en folds
// one byte in.
module crc_a
  import rx_frame_deframer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_A_PRESET;
    end else if (init) begin
      crc <= CRC_A_PRESET;
    end else if (en) begin
      crc <= crc_a_step(crc, data);
    end
  end

endmodule

// File: rtl/rx_frame_deframer.sv
// Deframes decoded PCD->PICC bits into bytes: LSb-first assembly, odd parity
// strip/check, running CRC_A and frame status at end of comms.
module rx_frame_deframer
  import rx_frame_deframer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_soc,
  input  logic       in_eoc,
  input  logic       in_error,
  input  logic       in_bit,
  input  logic       in_bit_valid,
  output logic       out_soc,
  output logic [7:0] out_data,
  output logic [2:0] out_bits,
  output logic       out_valid,
  output logic       out_eoc,
  output logic       out_error,
  output logic       crc_ok
);

  // Handshake: every in_* pulse is a single-cycle strobe with no back-pressure;
  // every out_* pulse is a single-cycle strobe one clock after its cause, and
  // out_data/out_bits stay stable between out_valid strobes.

  deframer_state_e state, state_nxt;

  logic [7:0]  shift, shift_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [15:0] crc;
  logic        crc_init, crc_en;
  logic        parity_ok;

  logic       soc_nxt, valid_nxt, eoc_nxt, error_nxt, crc_ok_nxt;
  logic [7:0] data_nxt;
  logic [2:0] bits_nxt;

  assign parity_ok = (^shift) ^ in_bit;

  crc_a u_crc_a (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .data  (shift),
    .crc   (crc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; in_soc restarts the frame from any state
  always_comb begin
    state_nxt = state;
    if (in_soc) begin
      state_nxt = ST_DATA;
    end else begin
      case (state)
        ST_DATA: begin
          if (in_error) begin
            state_nxt = ST_ERROR;
          end else if (in_eoc) begin
            state_nxt = ST_IDLE;
          end else if (in_bit_valid && (bit_cnt == 4'd7)) begin
            state_nxt = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (in_error) begin
            state_nxt = ST_ERROR;
          end else if (in_eoc) begin
            state_nxt = ST_IDLE;
          end else if (in_bit_valid) begin
            state_nxt = parity_ok ? ST_DATA : ST_ERROR;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    soc_nxt     = 1'b0;
    valid_nxt   = 1'b0;
    eoc_nxt     = 1'b0;
    error_nxt   = 1'b0;
    crc_ok_nxt  = 1'b0;
    data_nxt    = out_data;
    bits_nxt    = out_bits;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    if (in_soc) begin
      soc_nxt     = 1'b1;
      shift_nxt   = 8'h00;
      bit_cnt_nxt = 4'd0;
      crc_init    = 1'b1;
    end else begin
      case (state)
        ST_DATA: begin
          if (in_error) begin
            error_nxt = 1'b1;
          end else if (in_eoc) begin
            eoc_nxt = 1'b1;
            if (bit_cnt != 4'd0) begin
              // Short trailing byte: no parity, not part of the CRC
              valid_nxt = 1'b1;
              data_nxt  = shift;
              bits_nxt  = bit_cnt[2:0];
            end else begin
              crc_ok_nxt = (crc == CRC_A_RESIDUE);
            end
          end else if (in_bit_valid) begin
            shift_nxt[bit_cnt[2:0]] = in_bit;
            bit_cnt_nxt             = bit_cnt + 4'd1;
          end
        end
        ST_PARITY: begin
          if (in_error || in_eoc) begin
            error_nxt = 1'b1;
          end else if (in_bit_valid) begin
            if (parity_ok) begin
              valid_nxt   = 1'b1;
              data_nxt    = shift;
              bits_nxt    = 3'd0;
              crc_en      = 1'b1;
              shift_nxt   = 8'h00;
              bit_cnt_nxt = 4'd0;
            end else begin
              error_nxt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= 8'h00;
      bit_cnt   <= 4'd0;
      out_soc   <= 1'b0;
      out_data  <= 8'h00;
      out_bits  <= 3'd0;
      out_valid <= 1'b0;
      out_eoc   <= 1'b0;
      out_error <= 1'b0;
      crc_ok    <= 1'b0;
    end else begin
      shift     <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      out_soc   <= soc_nxt;
      out_data  <= data_nxt;
      out_bits  <= bits_nxt;
      out_valid <= valid_nxt;
      out_eoc   <= eoc_nxt;
      out_error <= error_nxt;
      crc_ok    <= crc_ok_nxt;
    end
  end

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Directed bench for rx_frame_deframer: stimulus pushes expected output
// events into a queue, a negedge monitor pops and compares them.
module tb_rx_frame_deframer;

  localparam int W = 16;

  logic       clk;
  logic       rst_n;
  logic       in_soc, in_eoc, in_error, in_bit, in_bit_valid;
  logic       out_soc, out_valid, out_eoc, out_error, crc_ok;
  logic [7:0] out_data;
  logic [2:0] out_bits;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs, exp_w;
  int vectors;
  int miscompares;

  rx_frame_deframer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_soc       (in_soc),
    .in_eoc       (in_eoc),
    .in_error     (in_error),
    .in_bit       (in_bit),
    .in_bit_valid (in_bit_valid),
    .out_soc      (out_soc),
    .out_data     (out_data),
    .out_bits     (out_bits),
    .out_valid    (out_valid),
    .out_eoc      (out_eoc),
    .out_error    (out_error),
    .crc_ok       (crc_ok)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert ($onehot0({in_soc, in_eoc, in_error, in_bit_valid}))
      else $error("input pulses overlap");
  end

  // Event word: {soc, valid, eoc, error, crc_ok, bits, data}
  function automatic logic [W-1:0] ev(input logic soc, input logic valid,
                                      input logic eoc, input logic err,
                                      input logic ok, input logic [2:0] bits,
                                      input logic [7:0] data);
    return {soc, valid, eoc, err, ok, bits, data};
  endfunction

  // Driver tasks
  task automatic pulse(input logic soc, input logic eoc, input logic err,
                       input logic bv, input logic b);
    @(negedge clk);
    in_soc = soc; in_eoc = eoc; in_error = err; in_bit_valid = bv; in_bit = b;
    @(posedge clk);
    #1;
    in_soc = 1'b0; in_eoc = 1'b0; in_error = 1'b0; in_bit_valid = 1'b0; in_bit = 1'b0;
  endtask

  task automatic send_soc();   pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic send_eoc();   pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic send_err();   pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic send_bit(input logic b); pulse(1'b0, 1'b0, 1'b0, 1'b1, b); endtask

  task automatic send_bits(input logic [7:0] data, input int n);
    for (int i = 0; i < n; i++) send_bit(data[i]);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic par);
    send_bits(data, 8);
    send_bit(par);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    logic [W-1:0] got;
    got = {out_soc, out_valid, out_eoc, out_error, crc_ok, out_bits, out_data};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, got, {W{1'b0}});
    end
  endtask

  task automatic check_hold(input string name, input logic [7:0] data,
                            input logic [2:0] bits);
    vectors++;
    if (out_data !== data || out_bits !== bits) begin
      miscompares++;
      $display("FAIL %s got=%h/%0d want=%h/%0d", name, out_data, out_bits, data, bits);
    end
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (out_soc || out_valid || out_eoc || out_error || crc_ok)) begin
        obs = {out_soc, out_valid, out_eoc, out_error, crc_ok,
               out_valid ? out_bits : 3'd0, out_valid ? out_data : 8'h00};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output got=%h want=none", obs);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs !== exp_w) begin
            miscompares++;
            $display("FAIL output_event got=%h want=%h", obs, exp_w);
          end
        end
      end
    end
  end

  task automatic reqa_frame();
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 8'h00));
    send_soc();
    send_bits(8'h26, 7);
    exp_q.push_back(ev(0, 1, 1, 0, 0, 3'd7, 8'h26));
    send_eoc();
    idle(3);
    check_hold("reqa_hold", 8'h26, 3'd7);
  endtask

  task automatic hlta_frame(input logic [7:0] last, input logic last_par,
                            input logic ok);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 8'h00));
    send_soc();
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd0, 8'h50)); send_byte(8'h50, 1'b1);
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd0, 8'h00)); send_byte(8'h00, 1'b1);
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd0, 8'h57)); send_byte(8'h57, 1'b0);
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd0, last));  send_byte(last, last_par);
    exp_q.push_back(ev(0, 0, 1, 0, ok, 3'd0, 8'h00));
    send_eoc();
    idle(3);
  endtask

  task automatic one_byte_93();
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 8'h00));
    send_soc();
    exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd0, 8'h93));
    send_byte(8'h93, 1'b1);
    exp_q.push_back(ev(0, 0, 1, 0, 0, 3'd0, 8'h00));
    send_eoc();
    idle(3);
  endtask

  // Stimulus
  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in_soc = 1'b0; in_eoc = 1'b0; in_error = 1'b0; in_bit = 1'b0; in_bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Ignored before any SOC
    send_eoc();
    send_bit(1'b1);
    idle(2);

    // REQA, 7-bit short frame
    reqa_frame();

    // HLTA with good and bad CRC
    hlta_frame(8'hCD, 1'b0, 1'b1);
    check_hold("hlta_hold", 8'hCD, 3'd0);
    hlta_frame(8'hCC, 1'b1, 1'b0);

    // Parity error, trailing bits and EOC ignored, then clean frame
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 8'h00));
    send_soc();
    send_bits(8'h50, 8);
    exp_q.push_back(ev(0, 0, 0, 1, 0, 3'd0, 8'h00));
    send_bit(1'b0);
    send_byte(8'hFF, 1'b1);
    send_eoc();
    idle(3);
    check_hold("parity_err_no_data", 8'hCC, 3'd0);
    one_byte_93();

    // Mid-frame SOC discards the partial byte
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 8'h00));
    send_soc();
    send_bits(8'h1F, 5);
    one_byte_93();

    // Upstream error mid-byte, EOC afterwards ignored
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 8'h00));
    send_soc();
    send_bits(8'h05, 3);
    exp_q.push_back(ev(0, 0, 0, 1, 0, 3'd0, 8'h00));
    send_err();
    send_eoc();
    idle(3);

    // EOC where the parity bit should be
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 8'h00));
    send_soc();
    send_bits(8'h50, 8);
    exp_q.push_back(ev(0, 0, 0, 1, 0, 3'd0, 8'h00));
    send_eoc();
    send_eoc();
    idle(3);

    // Empty frame: CRC still at preset, so not OK
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 8'h00));
    send_soc();
    exp_q.push_back(ev(0, 0, 1, 0, 0, 3'd0, 8'h00));
    send_eoc();
    idle(3);

    // Reset mid-frame
    exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 8'h00));
    send_soc();
    send_bits(8'h0A, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_midframe");
    idle(2);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    idle(2);
    send_eoc();
    idle(3);
    reqa_frame();

    idle(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_outputs got=%0d pending want=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
